// File: rtl/result_bcd_converter.sv
// result_bcd_converter
// Turns a two's-complement ALU result into a sign flag plus packed BCD
// digits. It uses iterative shift-and-add-3 (double dabble) and processes
// one magnitude bit per clock, with a start/done handshake.
module result_bcd_converter #(
  parameter int INPUT_WIDTH = 18,
  parameter int DIGITS      = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INPUT_WIDTH-1:0] value,
  output logic                   busy,
  output logic                   done,
  output logic                   sign,
  output logic [4*DIGITS-1:0]    bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(INPUT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [INPUT_WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]          scratch_q, scratch_d;
  logic                   sign_r_q, sign_r_d;
  logic                   sign_q, sign_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [BW-1:0]          adjusted;
  logic [BW-1:0]          shifted;
  logic                   last_shift;

  assign last_shift = (count_q == CW'(INPUT_WIDTH - 1));

  // State register; reset always wins over any pending start
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: accept only in IDLE, leave CONVERT after the last bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the current state
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Add 3 to every scratch digit that is 5 or more, so the coming shift carries correctly
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = BW'({adjusted, mag_q[INPUT_WIDTH-1]});
  end

  // Datapath next values: load magnitude on accept, shift while converting, publish on the last shift
  always_comb begin
    count_d   = count_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    sign_r_d  = sign_r_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_r_d  = value[INPUT_WIDTH-1];
          mag_d     = value[INPUT_WIDTH-1] ? (~value) + INPUT_WIDTH'(1) : value;
          scratch_d = '0;
          count_d   = '0;
        end
      end
      CONVERT: begin
        scratch_d = shifted;
        mag_d     = {mag_q[INPUT_WIDTH-2:0], 1'b0};
        count_d   = count_q + CW'(1);
        if (last_shift) begin
          bcd_d  = shifted;
          sign_d = sign_r_q;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers with synchronous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      mag_q     <= '0;
      scratch_q <= '0;
      sign_r_q  <= 1'b0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      count_q   <= count_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      sign_r_q  <= sign_r_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
    end
  end

  assign sign = sign_q;
  assign bcd  = bcd_q;

endmodule
